// File: rtl/ispm_loader_pkg.sv
// Shared types and constants for the instruction-scratchpad program loader.
package ispm_loader_pkg;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 13;
  localparam int unsigned MAX_WORDS = 4096;

  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CHK
  } state_e;

endpackage

// File: rtl/ispm_word_packer.sv
// Byte-to-word assembler: shifts bytes in little-endian order and flags the
// fourth byte of each word. word_o already includes the byte on byte_i so the
// caller can capture a complete word on the same edge that accepts byte 3.
module ispm_word_packer
  import ispm_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              stb_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              last_o
);

  logic [1:0]        lane_q;
  logic [DATA_W-1:0] shift_q;

  // Newest byte enters at the top; after four strobes byte 0 sits in bits 7:0.
  assign word_o = {byte_i, shift_q[DATA_W-1:8]};
  assign last_o = stb_i && (lane_q == 2'd3);

  // Lane index and assembly register; lane wraps to 0 after the 4th byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (clr_i) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (stb_i) begin
      lane_q  <= lane_q + 2'd1;
      shift_q <= word_o;
    end
  end

endmodule

// File: rtl/ispm_loader.sv
// Host-side program loader: parses A5 / N(16b LE) / 4N data bytes, writes
// packed 32-bit words to the instruction scratchpad from address 0 and holds
// the core in reset while loading.
// Optional feature macro: ISPM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module ispm_loader
  import ispm_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        io_rx_data,
  input  logic              io_rx_valid,
  output logic              io_rx_ready,
  output logic [ADDR_W-1:0] io_ispm_addr,
  output logic              io_ispm_enable,
  output logic              io_ispm_write,
  output logic [DATA_W-1:0] io_ispm_data_in,
  output logic              io_core_hold,
  output logic              io_done,
  output logic              io_error
);

  state_e            state_q;
  logic              rx_ready_q;
  logic [CNT_W-1:0]  word_idx_q;
  logic [CNT_W-1:0]  count_q;
  logic [7:0]        len_lo_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;
`ifdef ISPM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic              rx_fire;
  logic              is_magic;
  logic [15:0]       len_full;
  logic              pk_clr;
  logic              pk_stb;
  logic              pk_last;
  logic [DATA_W-1:0] pk_word;
  logic              more_words;

  assign rx_fire    = io_rx_valid && rx_ready_q;
  assign is_magic   = (io_rx_data == MAGIC);
  assign len_full   = {io_rx_data, len_lo_q};
  assign pk_clr     = rx_fire && (state_q == S_IDLE) && is_magic;
  assign pk_stb     = rx_fire && (state_q == S_DATA);
  assign more_words = (word_idx_q + CNT_W'(1)) < count_q;

  ispm_word_packer u_packer (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr_i  (pk_clr),
    .stb_i  (pk_stb),
    .byte_i (io_rx_data),
    .word_o (pk_word),
    .last_o (pk_last)
  );

  // Frame-parsing FSM with all outputs registered; ready drops only for the
  // WRITE cycle and stays low while in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b0;
      word_idx_q <= '0;
      count_q    <= '0;
      len_lo_q   <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef ISPM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          rx_ready_q <= 1'b1;
          if (rx_fire && is_magic) begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
            word_idx_q <= '0;
`ifdef ISPM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
            state_q    <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (rx_fire) begin
            len_lo_q <= io_rx_data;
            state_q  <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (rx_fire) begin
            if (len_full > 16'(MAX_WORDS)) begin
              err_q   <= 1'b1;
              hold_q  <= 1'b0;
              state_q <= S_IDLE;
            end else if (len_full == 16'd0) begin
`ifdef ISPM_LOADER_CHECKSUM_EN
              state_q <= S_CHK;
`else
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
              state_q <= S_IDLE;
`endif
            end else begin
              count_q <= len_full[CNT_W-1:0];
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (rx_fire) begin
`ifdef ISPM_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ io_rx_data;
`endif
            if (pk_last) begin
              rx_ready_q <= 1'b0;
              wen_q      <= 1'b1;
              addr_q     <= word_idx_q[ADDR_W-1:0];
              wdata_q    <= pk_word;
              state_q    <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          rx_ready_q <= 1'b1;
          if (more_words) begin
            word_idx_q <= word_idx_q + CNT_W'(1);
            state_q    <= S_DATA;
          end else begin
`ifdef ISPM_LOADER_CHECKSUM_EN
            state_q <= S_CHK;
`else
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
            state_q <= S_IDLE;
`endif
          end
        end

        S_CHK: begin
`ifdef ISPM_LOADER_CHECKSUM_EN
          if (rx_fire) begin
            if (io_rx_data == csum_q) begin
              done_q <= 1'b1;
            end else begin
              err_q  <= 1'b1;
            end
            hold_q  <= 1'b0;
            state_q <= S_IDLE;
          end
`else
          state_q <= S_IDLE;
`endif
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io_rx_ready     = rx_ready_q;
  assign io_ispm_addr    = addr_q;
  assign io_ispm_enable  = wen_q;
  assign io_ispm_write   = wen_q;
  assign io_ispm_data_in = wdata_q;
  assign io_core_hold    = hold_q;
  assign io_done         = done_q;
  assign io_error        = err_q;

endmodule

// File: tb/tb_ispm_loader.sv
`timescale 1ns/1ps
module tb_ispm_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic        hold;
    int          cyc;
  } wr_t;

`ifdef ISPM_LOADER_CHECKSUM_EN
  localparam int END_LAT = 0;
`else
  localparam int END_LAT = 1;
`endif

  logic        clk;
  logic        reset_n;
  logic [7:0]  io_rx_data;
  logic        io_rx_valid;
  logic        io_rx_ready;
  logic [11:0] io_ispm_addr;
  logic        io_ispm_enable;
  logic        io_ispm_write;
  logic [31:0] io_ispm_data_in;
  logic        io_core_hold;
  logic        io_done;
  logic        io_error;

  ispm_loader dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .io_rx_data      (io_rx_data),
    .io_rx_valid     (io_rx_valid),
    .io_rx_ready     (io_rx_ready),
    .io_ispm_addr    (io_ispm_addr),
    .io_ispm_enable  (io_ispm_enable),
    .io_ispm_write   (io_ispm_write),
    .io_ispm_data_in (io_ispm_data_in),
    .io_core_hold    (io_core_hold),
    .io_done         (io_done),
    .io_error        (io_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Bus monitor: every enabled cycle is one observed write.
  wr_t wq[$];
  int  cyc = 0;
  int  strobe_bad = 0;
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (io_ispm_enable === 1'b1) begin
      e.addr = io_ispm_addr;
      e.data = io_ispm_data_in;
      e.hold = io_core_hold;
      e.cyc  = cyc;
      wq.push_back(e);
    end
    if (io_ispm_write !== io_ispm_enable) strobe_bad++;
  end

  // ---------------- reference-model helpers ----------------
  function automatic wq_t rand_words(input int n);
    wq_t w;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    return w;
  endfunction

  function automatic bq_t build_frame(input wq_t w);
    bq_t q;
    logic [15:0] n;
`ifdef ISPM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    n = 16'(w.size());
    q.push_back(8'hA5);
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    foreach (w[i]) begin
      for (int k = 0; k < 4; k++) begin
        q.push_back(w[i][8*k +: 8]);
`ifdef ISPM_LOADER_CHECKSUM_EN
        x = x ^ w[i][8*k +: 8];
`endif
      end
    end
`ifdef ISPM_LOADER_CHECKSUM_EN
    q.push_back(x);
`endif
    return q;
  endfunction

  // mode 0: full rate, 1: one idle cycle before each byte, 2: random gaps
  task automatic send_bytes(input bq_t q, input int mode);
    int tries;
    int gap;
    foreach (q[i]) begin
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      repeat (gap) begin
        io_rx_valid = 1'b0;
        @(negedge clk);
      end
      io_rx_data  = q[i];
      io_rx_valid = 1'b1;
      tries = 0;
      while (io_rx_ready !== 1'b1 && tries < 50) begin
        @(negedge clk);
        tries++;
      end
      if (io_rx_ready !== 1'b1) begin
        total++; bad++;
        $display("FAIL rx_timeout: ready=%b required 1", io_rx_ready);
      end
      @(negedge clk);
      io_rx_valid = 1'b0;
    end
  endtask

  task automatic check_end(input string nm, input logic exp_done, input logic exp_err, input int lat);
    if (lat > 0) begin
      total++;
      if ({io_done, io_core_hold} !== 2'b01) begin
        bad++;
        $display("FAIL %s_pre: done,hold=%b%b required 01", nm, io_done, io_core_hold);
      end
      repeat (lat) @(negedge clk);
    end
    total++;
    if ({io_done, io_error, io_core_hold} !== {exp_done, exp_err, 1'b0}) begin
      bad++;
      $display("FAIL %s_end: done,err,hold=%b%b%b required %b%b0", nm,
               io_done, io_error, io_core_hold, exp_done, exp_err);
    end
  endtask

  task automatic check_writes(input string nm, input wq_t w);
    #1;
    total++;
    if (wq.size() != w.size()) begin
      bad++;
      $display("FAIL %s_count: writes=%0d required %0d", nm, wq.size(), w.size());
    end else begin
      foreach (w[i]) begin
        total++;
        if (wq[i].addr !== 12'(i) || wq[i].data !== w[i] || wq[i].hold !== 1'b1) begin
          bad++;
          $display("FAIL %s_w%0d: addr=%h data=%h hold=%b required addr=%h data=%h hold=1",
                   nm, i, wq[i].addr, wq[i].data, wq[i].hold, 12'(i), w[i]);
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    total++;
    if ({io_rx_ready, io_ispm_enable, io_ispm_write, io_core_hold, io_done, io_error} !== 6'b0 ||
        io_ispm_addr !== 12'h000 || io_ispm_data_in !== 32'h0) begin
      bad++;
      $display("FAIL %s: rdy,en,wr,hold,done,err=%b%b%b%b%b%b addr=%h data=%h required all 0", nm,
               io_rx_ready, io_ispm_enable, io_ispm_write, io_core_hold, io_done, io_error,
               io_ispm_addr, io_ispm_data_in);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b1;
    io_rx_valid = 1'b0;
    io_rx_data = 8'h00;
    #2 reset_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_state");
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (io_rx_ready !== 1'b1 || io_core_hold !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: ready=%b hold=%b required 1 0", io_rx_ready, io_core_hold);
    end
  endtask

  task automatic test_full_rate();
    wq_t w;
    w.push_back(32'h12345678);
    w.push_back(32'hDEADBEEF);
    wq.delete();
    send_bytes(build_frame(w), 0);
    check_end("full_rate", 1'b1, 1'b0, END_LAT);
    check_writes("full_rate", w);
    total++;
    if (wq.size() == 2 && (wq[1].cyc - wq[0].cyc) != 5) begin
      bad++;
      $display("FAIL full_rate_spacing: gap=%0d required 5", wq[1].cyc - wq[0].cyc);
    end
  endtask

  task automatic test_junk_prefix();
    wq_t w;
    bq_t q;
    w = rand_words(1);
    q = build_frame(w);
    q.push_front(8'hFF);
    q.push_front(8'h00);
    wq.delete();
    send_bytes(q, 0);
    check_end("junk", 1'b1, 1'b0, END_LAT);
    check_writes("junk", w);
  endtask

  task automatic test_len_error();
    bq_t q;
    wq_t w;
    q.push_back(8'hA5);
    q.push_back(8'h01);
    q.push_back(8'h10);
    wq.delete();
    send_bytes(q, 0);
    check_end("len4097", 1'b0, 1'b1, 0);
    repeat (3) @(negedge clk);
    check_writes("len4097", w);
    w = rand_words(2);
    send_bytes(build_frame(w), 0);
    check_end("after_err", 1'b1, 1'b0, END_LAT);
    check_writes("after_err", w);
  endtask

  task automatic test_zero_len();
    wq_t w;
    wq.delete();
    send_bytes(build_frame(w), 0);
    check_end("zero_len", 1'b1, 1'b0, 0);
    repeat (2) @(negedge clk);
    check_writes("zero_len", w);
  endtask

`ifdef ISPM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bq_t q;
    wq_t w;
    w.push_back(32'h04030201);
    q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    wq.delete();
    send_bytes(q, 0);
    check_end("csum_ok", 1'b1, 1'b0, 0);
    check_writes("csum_ok", w);
    q[7] = 8'h05;
    wq.delete();
    send_bytes(q, 0);
    check_end("csum_bad", 1'b0, 1'b1, 0);
    check_writes("csum_bad", w);
  endtask
`else
  task automatic test_trailing_byte();
    bq_t q;
    wq_t w;
    w.push_back(32'h04030201);
    q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    wq.delete();
    send_bytes(q, 0);
    check_end("trail", 1'b1, 1'b0, 1);
    q = '{8'h04};
    send_bytes(q, 0);
    repeat (2) @(negedge clk);
    check_end("trail_after", 1'b1, 1'b0, 0);
    check_writes("trail", w);
  endtask
`endif

  task automatic test_valid_toggle();
    wq_t w;
    w = rand_words(3);
    wq.delete();
    send_bytes(build_frame(w), 1);
    check_end("toggle", 1'b1, 1'b0, END_LAT);
    check_writes("toggle", w);
  endtask

  task automatic test_reset_midframe();
    bq_t q;
    wq_t w;
    q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    wq.delete();
    send_bytes(q, 0);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midframe_reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_writes("midframe_reset", w);
    w = rand_words(2);
    send_bytes(build_frame(w), 0);
    check_end("post_reset", 1'b1, 1'b0, END_LAT);
    check_writes("post_reset", w);
  endtask

  task automatic test_random_frames();
    wq_t w;
    bq_t q;
    logic [7:0] j;
    for (int f = 0; f < 6; f++) begin
      w = rand_words(int'($urandom_range(1, 5)));
      q = build_frame(w);
      for (int k = int'($urandom_range(0, 2)); k > 0; k--) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h5A;
        q.push_front(j);
      end
      wq.delete();
      send_bytes(q, 2);
      check_end($sformatf("rand%0d", f), 1'b1, 1'b0, END_LAT);
      check_writes($sformatf("rand%0d", f), w);
    end
  endtask

  task automatic test_max_len();
    wq_t w;
    int errs;
    w = rand_words(4096);
    wq.delete();
    send_bytes(build_frame(w), 0);
    check_end("max_len", 1'b1, 1'b0, END_LAT);
    #1;
    errs = 0;
    if (wq.size() != 4096) errs = 1;
    else foreach (w[i]) if (wq[i].addr !== 12'(i) || wq[i].data !== w[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL max_len_writes: writes=%0d bad_words=%0d required 4096 and 0", wq.size(), errs);
    end
  endtask

  task automatic test_strobe_pairing();
    total++;
    if (strobe_bad != 0) begin
      bad++;
      $display("FAIL write_strobe: cycles with write!=enable=%0d required 0", strobe_bad);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_junk_prefix();
    test_len_error();
    test_zero_len();
`ifdef ISPM_LOADER_CHECKSUM_EN
    test_checksum();
`else
    test_trailing_byte();
`endif
    test_valid_toggle();
    test_reset_midframe();
    test_random_frames();
    test_max_len();
    test_strobe_pairing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ispm_loader.md
# ispm_loader

Host-side program loader sitting directly upstream of the instruction scratchpad's bus port. It accepts a framed byte stream from a serial/host receiver through a valid/ready handshake, packs bytes into 32-bit little-endian words and issues one single-cycle write per word into the scratchpad, starting at word address 0. While a load is in progress it holds the core in reset, and it reports completion or frame errors.

## Interface
- No parameters. Widths are fixed by the 4096-word scratchpad: 12-bit word address, 32-bit data.
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- io_rx_data  in  8  incoming byte
- io_rx_valid  in  1  byte present
- io_rx_ready  out  1  loader accepts the byte; transfer when valid && ready
- io_ispm_addr  out  12  scratchpad word address
- io_ispm_enable  out  1  scratchpad bus enable
- io_ispm_write  out  1  scratchpad bus write strobe
- io_ispm_data_in  out  32  write data
- io_core_hold  out  1  high while a load is in progress
- io_done  out  1  last load completed cleanly (level)
- io_error  out  1  last load aborted (level)

## Operation
- Frame: magic byte 0xA5, then count N as 16 bits little-endian (low byte first), then 4N data bytes (each word little-endian), then one checksum byte if checksum support is compiled in.
- States: IDLE -> LEN_LO -> LEN_HI -> DATA <-> WRITE -> (CHK) -> IDLE. Error exits also go to IDLE.
- IDLE: rx_ready=1. Non-magic bytes are discarded. Accepting 0xA5 does four things:
  - clears done and error;
  - sets core_hold;
  - clears the word address and the byte index;
  - clears the checksum accumulator.
- LEN_LO and LEN_HI: capture N.
  - N > 4096: set error, drop hold, go to IDLE.
  - N == 0: set done (or go to CHK when checksum is enabled, with expected checksum 0x00).
- DATA: each accepted byte is placed in lane byte_index (byte 0 is bits 7:0). When the 4th byte is accepted, go to WRITE.
- WRITE: exactly one cycle with enable=1, write=1, addr = word index, data = packed word; rx_ready=0. Then:
  - word index + 1 < N: increment the word index and return to DATA;
  - otherwise: go to CHK, or finish.
- Finish: done=1, hold=0, go to IDLE.
- The word index is 13 bits internally. Only bits 11:0 drive addr; N ≤ 4096 guarantees no wrap.
- The bus port is write-only from this block. Scratchpad read data and ready are not consumed.

## Timing
- Reset values: rx_ready=0 during reset and 1 in the first cycle after release (IDLE). All ispm outputs are 0; hold, done and error are 0.
- The ispm enable/write/addr/data outputs are registered. They are 0 outside WRITE; data is held stable but is don't-care.
- Minimum 5 cycles per word with rx_valid held high: 4 accept cycles plus 1 WRITE cycle.
- The write occurs in the cycle after the 4th byte of a word is accepted.
- done/error change in the cycle after the final accepting edge.
- Asserting reset_n low mid-frame aborts immediately. All state returns to reset values and nothing already written is undone.
- io_rx_data is sampled only on handshake cycles; valid without ready has no effect.

## Configuration
- ISPM_LOADER_CHECKSUM_EN defined: after the last WRITE, the CHK state (rx_ready=1) accepts one byte and compares it with the XOR of all 4N data bytes.
  - Match: done.
  - Mismatch: error=1, done=0, hold=0.
- Undefined: there is no CHK state. Done is set straight after the last WRITE, and any byte following the data is treated as an IDLE byte.

## Structure
- Package ispm_loader_pkg holds:
  - the state enum;
  - MAGIC = 8'hA5;
  - MAX_WORDS = 4096;
  - ADDR_W = 12 and DATA_W = 32.
- Sub-module ispm_word_packer: takes a byte plus a strobe, keeps a 2-bit lane index and a 32-bit shift/assemble register, and flags the 4th byte. It has a synchronous clear.
- The FSM, the word counter and the checksum accumulator stay in the top module.

## Test plan
- Frame A5 02 00 78 56 34 12 EF BE AD DE at full rate -> writes 0x12345678 @0 and 0xDEADBEEF @1, each a single WRITE cycle exactly 5 cycles apart; done=1, hold=0.
- Bytes 00 FF before A5 01 00 … -> junk ignored; one write @0.
- Count 01 10 (N=4097) -> error=1, no bus write; the next valid frame clears error.
- With ISPM_LOADER_CHECKSUM_EN, frame A5 01 00 01 02 03 04 04 -> done. Same frame with trailing 05 -> error=1, and the write @0 still occurred.
- rx_valid toggling every other cycle over a 3-word frame -> same writes, correct addresses, done.
- reset_n pulsed low after 2 data bytes -> all outputs at reset values, no write; the subsequent full frame loads correctly.
